spi_reg_writer: RTL and testbench
=================================

// Module: spi_reg_writer
// PURPOSE
//  SPI mode-0 controller (initiator) that writes one 8-bit register per request into the
//  on-chip SPI register peripheral (en_reg_out/en_reg_pwm/pwm_duty_cycle bank).
//  Drives SCLK/nCS/COPI from a valid/ready request port. Used as an on-chip configuration
//  master and as the bench-side driver for peripheral verification.
// PARAMETERS
//  CLK_DIV   4  clk cycles per SCLK half-period; must be >=4 (peripheral 2-FF syncs SCLK), elab error otherwise
//  CS_SETUP  2  clk cycles from nCS fall to first SCLK rise window start
//  CS_HOLD   2  clk cycles from last SCLK fall to nCS rise
//  IDLE_GAP  2  clk cycles nCS held high after a frame before next request is accepted
// PORTS
//  clk        in   1  system clock
//  rst_n      in   1  async active-low reset
//  req_valid  in   1  request present
//  req_ready  out  1  high only in IDLE; transfer on req_valid&&req_ready at posedge clk
//  req_addr   in   7  register address (0x00..0x04 used by peripheral)
//  req_data   in   8  register write data
//  sclk       out  1  SPI clock, idle low (mode 0)
//  ncs        out  1  chip select, active low
//  copi       out  1  serial data, MSB first
//  busy       out  1  high from accept until return to IDLE (incl. gap)
//  done       out  1  one-cycle pulse, cycle after nCS rises on a completed frame
// BEHAVIOUR
//  - Reset (async, any state): sclk=0, ncs=1, copi=0, busy=0, done=0, req_ready=1, state=IDLE.
//    Reset mid-frame aborts it: no done pulse, no partial retry.
//  - Frame: 16 bits {1'b1 (write), req_addr[6:0], req_data[7:0]}, latched at accept; bit15 first.
//  - All outputs registered; req_ready = (state==IDLE) may be combinational from state reg.
//  - FSM: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
//    IDLE : ncs=1, sclk=0, copi=0. On accept (edge E0): ncs<=0, copi<=frame[15], busy<=1, ->SETUP.
//    SETUP: CS_SETUP cycles, outputs stable, ->SHIFT.
//    SHIFT: per bit 2*CLK_DIV cycles: CLK_DIV low (copi stable), sclk<=1 for CLK_DIV high;
//           on falling edge shift copi to next bit. After 16th high phase sclk<=0, ->HOLD.
//           Bit counter 4-bit wraps 15->0 only on exit; exactly 16 rising edges per frame.
//    HOLD : CS_HOLD cycles, copi holds bit0; then ncs<=1, copi<=0, ->GAP.
//    GAP  : done=1 first cycle only; IDLE_GAP cycles; busy<=0 on exit to IDLE.
//  - nCS rises at edge E0 + CS_SETUP + 32*CLK_DIV + CS_HOLD; done high for following cycle.
//  - req_valid while busy: ignored, not queued; request inputs only sampled at accept.
//  - req_valid held continuously: back-to-back frames separated by exactly IDLE_GAP+1 ncs-high cycles.
//  - sclk never toggles while ncs high; copi changes only while sclk low.
// STRUCTURE
//  - Shared package spi_pkg: SPI_FRAME_W=16, SPI_RW_WRITE=1'b1, register address localparams
//    (ADDR_EN_OUT_7_0=0x00, ADDR_EN_OUT_15_8=0x01, ADDR_EN_PWM_7_0=0x02, ADDR_EN_PWM_15_8=0x03,
//    ADDR_PWM_DUTY=0x04), FSM state enum.
//  - Sub-module spi_sclk_gen: half-period tick counter (CLK_DIV), enable/clear from FSM;
//    FSM + 16-bit shift register + bit counter stay in this module.
// TESTING (bench connects sclk/ncs/copi to peripheral ui_in[0]/[2]/[1], CLK_DIV=4)
//  1 Write addr 0x04 data 0x80 -> copi stream 0x8480 MSB first, 16 sclk rises,
//    peripheral pwm_duty_cycle==0x80, done one pulse, busy low after gap.
//  2 Writes 0x00<-0xFF then 0x02<-0x0F with req_valid held -> en_reg_out_7_0=0xFF,
//    en_reg_pwm_7_0=0x0F; ncs high exactly IDLE_GAP+1 cycles between frames.
//  3 Timing check: nCS fall to nCS rise = CS_SETUP+32*CLK_DIV+CS_HOLD = 132 clk; copi stable
//    around every sclk rise; sclk low whenever ncs high.
//  4 Assert rst_n low after 7th sclk rise -> ncs=1, sclk=0, copi=0 immediately; no done;
//    peripheral registers unchanged; next request completes normally.
//  5 Pulse req_valid with new addr/data during SHIFT -> ignored; in-flight frame bits unchanged.
//  6 CLK_DIV=8, CS_SETUP=0, IDLE_GAP=0 -> frame still correct; write 0x03<-0xA5 lands.

Source files
------------

// File: rtl/spi_reg_writer_pkg.sv
// Shared definitions for the SPI register writer: frame layout, peripheral
// register map and controller state encoding.
package spi_pkg;

    localparam int   SPI_FRAME_W  = 16;
    localparam int   SPI_ADDR_W   = 7;
    localparam int   SPI_DATA_W   = 8;
    localparam logic SPI_RW_WRITE = 1'b1;

    localparam logic [SPI_ADDR_W-1:0] ADDR_EN_OUT_7_0  = 7'h00;
    localparam logic [SPI_ADDR_W-1:0] ADDR_EN_OUT_15_8 = 7'h01;
    localparam logic [SPI_ADDR_W-1:0] ADDR_EN_PWM_7_0  = 7'h02;
    localparam logic [SPI_ADDR_W-1:0] ADDR_EN_PWM_15_8 = 7'h03;
    localparam logic [SPI_ADDR_W-1:0] ADDR_PWM_DUTY    = 7'h04;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } spi_state_e;

    function automatic logic [SPI_FRAME_W-1:0] spi_build_frame(
        input logic [SPI_ADDR_W-1:0] addr,
        input logic [SPI_DATA_W-1:0] data
    );
        return {SPI_RW_WRITE, addr, data};
    endfunction

endpackage

// File: rtl/spi_reg_writer_if.sv
// Request port plus SPI pins of the register writer. "master" is the requester,
// "slave" is the writer block that serves requests and drives the SPI lines.
interface spi_reg_writer_if;
    import spi_pkg::*;

    logic                  req_valid;
    logic                  req_ready;
    logic [SPI_ADDR_W-1:0] req_addr;
    logic [SPI_DATA_W-1:0] req_data;
    logic                  sclk;
    logic                  ncs;
    logic                  copi;
    logic                  busy;
    logic                  done;

    modport master (
        output req_valid, req_addr, req_data,
        input  req_ready, sclk, ncs, copi, busy, done
    );

    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ready, sclk, ncs, copi, busy, done
    );

endinterface

// File: rtl/spi_reg_writer_sclk_gen.sv
// Half-period tick generator: o_tick fires on the last clk cycle of each
// CLK_DIV-long SCLK half period while enabled.
module spi_sclk_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    localparam int unsigned CNT_W = $clog2(CLK_DIV);

    logic [CNT_W-1:0] r_cnt;
    logic             w_wrap;

    assign w_wrap = (r_cnt == CNT_W'(CLK_DIV - 32'd1));
    assign o_tick = i_en && w_wrap;

    // Half-period counter; parks at zero whenever the shifter is not running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr || !i_en || w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/spi_reg_writer.sv
// SPI mode-0 initiator writing one 8-bit peripheral register per accepted
// request as a 16-bit frame {write, addr[6:0], data[7:0]}, MSB first.
module spi_reg_writer
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned CS_SETUP = 2,
    parameter int unsigned CS_HOLD  = 2,
    parameter int unsigned IDLE_GAP = 2
) (
    input logic             clk,
    input logic             rst_n,
    spi_reg_writer_if.slave bus
);

    // The peripheral double-flops SCLK, so shorter half periods are unsafe.
    if (CLK_DIV < 4) begin : g_clk_div_check
        $error("spi_reg_writer: CLK_DIV must be >= 4");
    end

    spi_state_e             r_state;
    spi_state_e             w_state_nxt;
    logic [15:0]            r_cnt;
    logic [15:0]            w_cnt_nxt;
    logic [3:0]             r_bit_cnt;
    logic [3:0]             w_bit_nxt;
    logic [SPI_FRAME_W-1:0] r_shreg;
    logic [SPI_FRAME_W-1:0] w_shreg_nxt;
    logic                   r_sclk;
    logic                   w_sclk_nxt;
    logic                   r_ncs;
    logic                   w_ncs_nxt;
    logic                   r_busy;
    logic                   w_busy_nxt;
    logic                   r_done;
    logic                   w_done_nxt;
    logic                   w_ready;
    logic                   w_accept;
    logic                   w_tick;
    logic                   w_frame_end;

    assign w_ready  = (r_state == ST_IDLE);
    assign w_accept = bus.req_valid && w_ready;

    spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (r_state == ST_SHIFT),
        .i_clr  (w_accept),
        .o_tick (w_tick)
    );

    // State and output registers; copi is the shift register MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 16'd0;
            r_bit_cnt <= 4'd0;
            r_shreg   <= '0;
            r_sclk    <= 1'b0;
            r_ncs     <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit_cnt <= w_bit_nxt;
            r_shreg   <= w_shreg_nxt;
            r_sclk    <= w_sclk_nxt;
            r_ncs     <= w_ncs_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
        end
    end

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit_cnt;
        w_shreg_nxt = r_shreg;
        w_sclk_nxt  = r_sclk;
        w_ncs_nxt   = r_ncs;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_frame_end = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_sclk_nxt  = 1'b0;
                w_ncs_nxt   = 1'b1;
                w_shreg_nxt = '0;
                w_busy_nxt  = 1'b0;
                w_cnt_nxt   = 16'd0;
                w_bit_nxt   = 4'd0;
                if (w_accept) begin
                    w_shreg_nxt = spi_build_frame(bus.req_addr, bus.req_data);
                    w_ncs_nxt   = 1'b0;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = (CS_SETUP == 0) ? ST_SHIFT : ST_SETUP;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (r_cnt == 16'(CS_SETUP - 32'd1)) begin
                    w_cnt_nxt   = 16'd0;
                    w_state_nxt = ST_SHIFT;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            ST_SHIFT: begin
                if (w_tick && !r_sclk) begin
                    w_sclk_nxt = 1'b1;
                end else if (w_tick) begin
                    w_sclk_nxt = 1'b0;
                    // Last bit stays on copi through the hold window.
                    if (r_bit_cnt == 4'd15) begin
                        w_bit_nxt = 4'd0;
                        if (CS_HOLD == 0) begin
                            w_frame_end = 1'b1;
                        end else begin
                            w_state_nxt = ST_HOLD;
                        end
                    end else begin
                        w_bit_nxt   = r_bit_cnt + 4'd1;
                        w_shreg_nxt = {r_shreg[SPI_FRAME_W-2:0], 1'b0};
                    end
                end else begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_HOLD: begin
                if (r_cnt == 16'(CS_HOLD - 32'd1)) begin
                    w_frame_end = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            ST_GAP: begin
                if (r_cnt == 16'(IDLE_GAP - 32'd1)) begin
                    w_cnt_nxt   = 16'd0;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_ncs_nxt   = 1'b1;
                w_sclk_nxt  = 1'b0;
                w_shreg_nxt = '0;
                w_busy_nxt  = 1'b0;
            end
        endcase

        if (w_frame_end) begin
            w_ncs_nxt   = 1'b1;
            w_shreg_nxt = '0;
            w_done_nxt  = 1'b1;
            w_cnt_nxt   = 16'd0;
            if (IDLE_GAP == 0) begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = ST_IDLE;
            end else begin
                w_state_nxt = ST_GAP;
            end
        end else begin
            w_done_nxt = 1'b0;
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.sclk      = r_sclk;
    assign bus.ncs       = r_ncs;
    assign bus.copi      = r_shreg[SPI_FRAME_W-1];
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;

endmodule

// File: tb/tb_spi_reg_writer.sv
// Bench for spi_reg_writer: two instances (default timing and CLK_DIV=8 with no
// setup/gap) each feeding a behavioural SPI register peripheral.
module tb_spi_reg_writer;
    import spi_pkg::*;

    localparam int F0 = 2 + 32 * 4 + 2;
    localparam int G0 = 2;
    localparam int F1 = 0 + 32 * 8 + 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_reg_writer_if bus0 ();
    spi_reg_writer_if bus1 ();

    spi_reg_writer u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    spi_reg_writer #(.CLK_DIV(8), .CS_SETUP(0), .CS_HOLD(2), .IDLE_GAP(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1));

    logic [1:0] v = 2'b00;
    logic [6:0] a [2];
    logic [7:0] d [2];
    logic [1:0] t_ncs, t_sclk, t_copi, t_busy, t_done, t_rdy;

    assign bus0.req_valid = v[0];
    assign bus1.req_valid = v[1];
    assign bus0.req_addr  = a[0];
    assign bus1.req_addr  = a[1];
    assign bus0.req_data  = d[0];
    assign bus1.req_data  = d[1];
    assign t_ncs  = {bus1.ncs,  bus0.ncs};
    assign t_sclk = {bus1.sclk, bus0.sclk};
    assign t_copi = {bus1.copi, bus0.copi};
    assign t_busy = {bus1.busy, bus0.busy};
    assign t_done = {bus1.done, bus0.done};
    assign t_rdy  = {bus1.req_ready, bus0.req_ready};

    // Peripheral model and line-protocol watcher per instance.
    for (genvar g = 0; g < 2; g++) begin : g_mon
        int          bits = 0, frames = 0, dones = 0, viol = 0;
        int          len_last = 0, gap_last = 0, low_cnt = 0, high_cnt = 0;
        logic [15:0] sh = 16'h0000, last = 16'h0000;
        logic [7:0]  regs [0:4] = '{default: 8'h00};
        logic [15:0] rx_q [$];
        logic        p_ncs = 1'b1, p_sclk = 1'b0, p_copi = 1'b0;

        always @(negedge t_ncs[g]) bits = 0;

        always @(posedge t_sclk[g]) begin
            if (t_ncs[g] == 1'b0) begin
                sh = {sh[14:0], t_copi[g]};
                bits++;
                if (bits > 16) viol++;
            end
        end

        always @(posedge t_ncs[g]) begin
            if (bits == 16 && sh[15]) begin
                last = sh;
                frames++;
                rx_q.push_back(sh);
                if (sh[14:8] <= 7'd4) regs[sh[10:8]] = sh[7:0];
            end
        end

        always @(negedge clk) begin
            if (t_ncs[g] && t_sclk[g]) viol++;
            if (!p_sclk && t_sclk[g] && t_copi[g] !== p_copi) viol++;
            if (t_copi[g] !== p_copi && t_sclk[g]) viol++;
            if (t_done[g]) begin
                dones++;
                if (!(t_ncs[g] && !p_ncs)) viol++;
            end
            if (t_ncs[g]) begin
                if (!p_ncs) begin len_last = low_cnt; high_cnt = 0; end
                high_cnt++;
            end else begin
                if (p_ncs) begin gap_last = high_cnt; low_cnt = 0; end
                low_cnt++;
            end
            p_ncs  = t_ncs[g];
            p_sclk = t_sclk[g];
            p_copi = t_copi[g];
        end
    end

    int checks = 0, errors = 0;
    logic [7:0] exp_regs [2][0:4] = '{default: 8'h00};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_accept(input int g);
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            if (t_rdy[g] && v[g]) return;
        end
        chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done(input int g);
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (t_done[g]) return;
        end
        chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic write(input int g, input logic [6:0] addr, input logic [7:0] data);
        a[g] = addr; d[g] = data; v[g] = 1'b1;
        wait_accept(g);
        #1 v[g] = 1'b0;
        if (addr <= 7'd4) exp_regs[g][addr[2:0]] = data;
        wait_done(g);
        repeat (2) @(negedge clk);
    endtask

    typedef struct {
        logic [6:0]  addr;
        logic [7:0]  data;
        logic [15:0] frame;
    } vec_t;

    initial begin
        vec_t        vecs [6];
        int          d0, fr0, k, ne, rs;
        logic [15:0] exp_q [$];

        vecs[0] = '{ADDR_PWM_DUTY,    8'h80, 16'h8480};
        vecs[1] = '{ADDR_EN_OUT_7_0,  8'hFF, 16'h80FF};
        vecs[2] = '{ADDR_EN_PWM_7_0,  8'h0F, 16'h820F};
        vecs[3] = '{ADDR_EN_PWM_15_8, 8'hA5, 16'h83A5};
        vecs[4] = '{7'h7F,            8'h5A, 16'hFF5A};
        vecs[5] = '{ADDR_EN_OUT_15_8, 8'h00, 16'h8100};
        a[0] = 7'd0; a[1] = 7'd0; d[0] = 8'd0; d[1] = 8'd0;

        repeat (3) @(negedge clk);
        chk("rst_ncs",   t_ncs[0],  1);
        chk("rst_sclk",  t_sclk[0], 0);
        chk("rst_copi",  t_copi[0], 0);
        chk("rst_busy",  t_busy[0], 0);
        chk("rst_done",  t_done[0], 0);
        chk("rst_ready", t_rdy[0],  1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed single writes on the default-timing instance.
        for (int i = 0; i < 6; i++) begin
            d0 = g_mon[0].dones;
            write(0, vecs[i].addr, vecs[i].data);
            chk("frame",     g_mon[0].last,     vecs[i].frame);
            chk("bits",      g_mon[0].bits,     16);
            chk("ncs_low",   g_mon[0].len_last, F0);
            chk("done_once", g_mon[0].dones,    d0 + 1);
            chk("busy_gap",  t_busy[0],         0);
            chk("ready_gap", t_rdy[0],          1);
            if (vecs[i].addr <= 7'd4)
                chk("reg", g_mon[0].regs[vecs[i].addr[2:0]], vecs[i].data);
        end

        // Back-to-back with req_valid held: gap between frames.
        fr0 = g_mon[0].frames;
        a[0] = ADDR_EN_OUT_7_0; d[0] = 8'hFF; v[0] = 1'b1;
        wait_accept(0);
        #1 a[0] = ADDR_EN_PWM_7_0; d[0] = 8'h0F;
        wait_accept(0);
        #1 v[0] = 1'b0;
        exp_regs[0][0] = 8'hFF; exp_regs[0][2] = 8'h0F;
        wait_done(0);
        repeat (2) @(negedge clk);
        chk("b2b_frames", g_mon[0].frames,   fr0 + 2);
        chk("b2b_gap",    g_mon[0].gap_last, G0 + 1);
        chk("b2b_len",    g_mon[0].len_last, F0);
        chk("b2b_reg0",   g_mon[0].regs[0],  8'hFF);
        chk("b2b_reg2",   g_mon[0].regs[2],  8'h0F);

        // Reset after the 7th SCLK rise aborts the frame.
        d0 = g_mon[0].dones; fr0 = g_mon[0].frames;
        a[0] = ADDR_EN_OUT_15_8; d[0] = 8'h77; v[0] = 1'b1;
        wait_accept(0);
        #1 v[0] = 1'b0;
        for (int i = 0; i < 300 && g_mon[0].bits < 7; i++) @(negedge clk);
        chk("rst_reach7", g_mon[0].bits, 7);
        rst_n = 1'b0;
        #1;
        chk("abort_ncs",  t_ncs[0],  1);
        chk("abort_sclk", t_sclk[0], 0);
        chk("abort_copi", t_copi[0], 0);
        chk("abort_busy", t_busy[0], 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("abort_nodone", g_mon[0].dones,   d0);
        chk("abort_noframe", g_mon[0].frames, fr0);
        chk("abort_reg1",   g_mon[0].regs[1], exp_regs[0][1]);
        write(0, ADDR_EN_OUT_15_8, 8'h77);
        chk("after_rst_reg1", g_mon[0].regs[1], 8'h77);

        // New request pulsed mid-shift must be ignored.
        fr0 = g_mon[0].frames;
        a[0] = ADDR_EN_OUT_15_8; d[0] = 8'h3C; v[0] = 1'b1;
        wait_accept(0);
        #1 v[0] = 1'b0;
        exp_regs[0][1] = 8'h3C;
        for (int i = 0; i < 300 && g_mon[0].bits < 3; i++) @(negedge clk);
        a[0] = ADDR_EN_PWM_7_0; d[0] = 8'hFF; v[0] = 1'b1;
        repeat (2) @(negedge clk);
        v[0] = 1'b0;
        wait_done(0);
        repeat (F0) @(negedge clk);
        chk("ign_frame",  g_mon[0].last,    16'h813C);
        chk("ign_count",  g_mon[0].frames,  fr0 + 1);
        chk("ign_reg2",   g_mon[0].regs[2], exp_regs[0][2]);

        // Slow-clock instance without setup or gap.
        write(1, ADDR_EN_PWM_15_8, 8'hA5);
        chk("i1_frame", g_mon[1].last,     16'h83A5);
        chk("i1_reg3",  g_mon[1].regs[3],  8'hA5);
        chk("i1_len",   g_mon[1].len_last, F1);
        fr0 = g_mon[1].frames;
        a[1] = ADDR_PWM_DUTY; d[1] = 8'h11; v[1] = 1'b1;
        wait_accept(1);
        #1 a[1] = ADDR_EN_OUT_7_0; d[1] = 8'h22;
        wait_accept(1);
        #1 v[1] = 1'b0;
        wait_done(1);
        repeat (2) @(negedge clk);
        chk("i1_b2b_frames", g_mon[1].frames,   fr0 + 2);
        chk("i1_b2b_gap",    g_mon[1].gap_last, 1);
        chk("i1_reg4",       g_mon[1].regs[4],  8'h11);
        chk("i1_reg0",       g_mon[1].regs[0],  8'h22);

        // Random requests against an acceptance-window model.
        k = 0; ne = 0; rs = g_mon[0].rx_q.size();
        for (int c = 0; c < 3000; c++) begin
            chk("rand_ready", t_rdy[0], (k >= ne) ? 1 : 0);
            v[0] = ($urandom_range(0, 3) == 0);
            a[0] = 7'($urandom_range(0, 7));
            d[0] = 8'($urandom);
            @(posedge clk);
            if (v[0] && k >= ne) begin
                exp_q.push_back({1'b1, a[0], d[0]});
                if (a[0] <= 7'd4) exp_regs[0][a[0][2:0]] = d[0];
                ne = k + F0 + G0 + 1;
            end
            k++;
            @(negedge clk);
        end
        v[0] = 1'b0;
        repeat (F0 + 10) @(negedge clk);
        chk("rand_count", g_mon[0].rx_q.size() - rs, exp_q.size());
        for (int i = 0; i < exp_q.size() && rs + i < g_mon[0].rx_q.size(); i++)
            chk("rand_frame", g_mon[0].rx_q[rs + i], exp_q[i]);
        for (int r = 0; r < 5; r++)
            chk("rand_reg", g_mon[0].regs[r], exp_regs[0][r]);

        chk("proto0", g_mon[0].viol, 0);
        chk("proto1", g_mon[1].viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
